// File: rtl/pipe_stage_buf_pkg.sv
// ----------------------------------------------------------------------------
// pipe_stage_buf_pkg
//   Shared constants and sizing helpers for the pipeline-stage buffer.
//   Default payload width and FIFO depth live here, together with the width
//   rules for the occupancy counter and the read/write pointers, so the stage
//   and anything that instantiates it size their vectors the same way.
// ----------------------------------------------------------------------------
package pipe_stage_buf_pkg;

   localparam int unsigned DEF_WIDTH = 64;
   localparam int unsigned DEF_DEPTH = 2;

   // Occupancy runs 0..DEPTH inclusive, so it needs room for DEPTH+1 values.
   function automatic int unsigned count_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   // Pointers index 0..DEPTH-1; a depth of one still gets a 1-bit vector.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/pipe_stage_buf.sv
// ----------------------------------------------------------------------------
// pipe_stage_buf
//   Pipeline-stage register with a valid/ready handshake and a DEPTH-entry
//   skid FIFO. An empty stage drives NOP_VALUE so downstream sees a bubble.
//
//   Handshake: a beat moves on a port in every cycle where valid and ready are
//   both high at the rising edge (push = s_valid_i && s_ready_o,
//   pop = m_valid_o && m_ready_i). The sender holds data/valid stable until
//   the beat moves; ready may change freely. m_data_o is stable while
//   m_valid_o && !m_ready_i.
//
// Ports
//   clk_i      in   clock, all state on the rising edge
//   rst_ni     in   asynchronous active-low reset
//   flush_i    in   synchronous flush; drops every entry and any push that cycle
//   s_valid_i  in   upstream payload valid
//   s_ready_o  out  stage can accept (registered when REG_READY=1)
//   s_data_i   in   upstream payload [WIDTH-1:0]
//   m_valid_o  out  head entry valid (count_o != 0)
//   m_ready_i  in   downstream accepts the head
//   m_data_o   out  head entry, or NOP_VALUE when empty
//   count_o    out  current occupancy [$clog2(DEPTH+1)-1:0]
// ----------------------------------------------------------------------------
module pipe_stage_buf
   import pipe_stage_buf_pkg::*;
#(
   parameter int unsigned      WIDTH     = DEF_WIDTH,
   parameter int unsigned      DEPTH     = DEF_DEPTH,
   parameter logic [WIDTH-1:0] NOP_VALUE = '0,
   parameter bit               REG_READY = 1'b1
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       flush_i,
   input  logic                       s_valid_i,
   output logic                       s_ready_o,
   input  logic [WIDTH-1:0]           s_data_i,
   output logic                       m_valid_o,
   input  logic                       m_ready_i,
   output logic [WIDTH-1:0]           m_data_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int unsigned CW = count_width(DEPTH);
   localparam int unsigned PW = ptr_width(DEPTH);

   if (DEPTH == 1 && REG_READY == 1'b0) begin : g_plain
      // Single register with combinational ready: a beat can enter in the
      // same cycle the current one leaves, giving full throughput at depth 1.
      logic             valid_q, valid_d;
      logic [WIDTH-1:0] data_q, data_d;
      logic             push, pop;

      assign s_ready_o = !valid_q || m_ready_i;
      assign m_valid_o = valid_q;
      assign m_data_o  = valid_q ? data_q : NOP_VALUE;
      assign count_o   = CW'(valid_q);

      always_comb begin
         push    = s_valid_i && s_ready_o;
         pop     = valid_q && m_ready_i;
         valid_d = valid_q;
         data_d  = data_q;
         if (flush_i) begin
            valid_d = 1'b0;
         end else begin
            if (pop) begin
               valid_d = 1'b0;
            end
            if (push) begin
               valid_d = 1'b1;
               data_d  = s_data_i;
            end
         end
      end

      // The payload register carries no reset; valid_q alone qualifies it.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            valid_q <= 1'b0;
         end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
         end
      end

   end else begin : g_fifo
      localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

      logic [WIDTH-1:0] mem_q [DEPTH];
      logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
      logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
      logic [CW-1:0]    count_q, count_d;
      logic             ready_q, ready_d;
      logic             push, pop, full, mem_we;

      assign full = (count_q == CW'(DEPTH));

      // Registered ready keeps the stall off the combinational path; the
      // pass-through form lets a full stage accept while its head leaves.
      assign s_ready_o = REG_READY ? ready_q : (!full || m_ready_i);
      assign m_valid_o = (count_q != '0);
      assign m_data_o  = (count_q != '0) ? mem_q[rd_ptr_q] : NOP_VALUE;
      assign count_o   = count_q;

      always_comb begin
         push     = s_valid_i && s_ready_o;
         pop      = (count_q != '0) && m_ready_i;
         wr_ptr_d = wr_ptr_q;
         rd_ptr_d = rd_ptr_q;
         count_d  = count_q;
         mem_we   = 1'b0;
         if (flush_i) begin
            // Flush wins: the concurrent push is dropped along with the contents.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
         end else begin
            if (push) begin
               mem_we   = 1'b1;
               wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
               rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
         end
         // Computed from the post-flush occupancy, so ready drops on the
         // same edge that fills the last slot and returns after a flush.
         ready_d = (count_d < CW'(DEPTH));
      end

      // Storage and control share one block; the storage array is simply
      // left out of the reset branch, so it holds its contents through reset.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
         end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            if (mem_we) begin
               mem_q[wr_ptr_q] <= s_data_i;
            end
         end
      end
   end

   // A beat may enter a full stage only when the head leaves in that cycle.
   a_no_push_when_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (s_valid_i && s_ready_o && count_o == CW'(DEPTH)) |-> (m_valid_o && m_ready_i));

   a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
      count_o <= CW'(DEPTH));

   a_valid_matches_count : assert property (@(posedge clk_i) disable iff (!rst_ni)
      m_valid_o == (count_o != '0));

endmodule

// File: tb/tb_pipe_stage_buf.sv
// ----------------------------------------------------------------------------
// tb_pipe_stage_buf
//   Three stage buffers side by side: DEPTH=2 registered ready, DEPTH=3
//   registered ready, DEPTH=1 combinational ready. Each has a reference model
//   that is just a queue of buffered beats; outputs are compared with the
//   queue every cycle, plus directed checks for the corner cases.
// ----------------------------------------------------------------------------
module tb_pipe_stage_buf;

   localparam int N = 3;
   localparam int W = 16;
   localparam int DEP [N] = '{2, 3, 1};
   localparam bit RR  [N] = '{1'b1, 1'b1, 1'b0};
   localparam logic [W-1:0] NOP [N] = '{16'h0013, 16'hBEEF, 16'h5A5A};

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic         flush   [N];
   logic         s_valid [N];
   logic         s_ready [N];
   logic [W-1:0] s_data  [N];
   logic         m_valid [N];
   logic         m_ready [N];
   logic [W-1:0] m_data  [N];
   logic [1:0]   count_a;
   logic [1:0]   count_b;
   logic         count_c;

   pipe_stage_buf #(.WIDTH(W), .DEPTH(2), .NOP_VALUE(NOP[0]), .REG_READY(1'b1)) u_d2 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[0]),
      .s_valid_i(s_valid[0]), .s_ready_o(s_ready[0]), .s_data_i(s_data[0]),
      .m_valid_o(m_valid[0]), .m_ready_i(m_ready[0]), .m_data_o(m_data[0]),
      .count_o(count_a));

   pipe_stage_buf #(.WIDTH(W), .DEPTH(3), .NOP_VALUE(NOP[1]), .REG_READY(1'b1)) u_d3 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[1]),
      .s_valid_i(s_valid[1]), .s_ready_o(s_ready[1]), .s_data_i(s_data[1]),
      .m_valid_o(m_valid[1]), .m_ready_i(m_ready[1]), .m_data_o(m_data[1]),
      .count_o(count_b));

   pipe_stage_buf #(.WIDTH(W), .DEPTH(1), .NOP_VALUE(NOP[2]), .REG_READY(1'b0)) u_d1 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[2]),
      .s_valid_i(s_valid[2]), .s_ready_o(s_ready[2]), .s_data_i(s_data[2]),
      .m_valid_o(m_valid[2]), .m_ready_i(m_ready[2]), .m_data_o(m_data[2]),
      .count_o(count_c));

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q [N][$];
   int  total = 0;
   int  bad   = 0;
   int  dut_beats [N];
   bit  pending [N];
   int  max_cnt1 = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int dut_count(input int i);
      case (i)
         0:       return int'(count_a);
         1:       return int'(count_b);
         default: return int'(count_c);
      endcase
   endfunction

   function automatic bit exp_ready(input int i);
      if (RR[i]) return exp_q[i].size() < DEP[i];
      return (exp_q[i].size() < DEP[i]) || m_ready[i];
   endfunction

   task automatic check_outputs();
      for (int i = 0; i < N; i++) begin
         int sz;
         sz = exp_q[i].size();
         check_eq($sformatf("u%0d.m_valid", i), 32'(m_valid[i]), 32'(sz != 0));
         check_eq($sformatf("u%0d.m_data", i), 32'(m_data[i]),
                  32'((sz != 0) ? exp_q[i][0] : NOP[i]));
         check_eq($sformatf("u%0d.count", i), 32'(dut_count(i)), 32'(sz));
         check_eq($sformatf("u%0d.s_ready", i), 32'(s_ready[i]), 32'(exp_ready(i)));
         if (m_valid[i] && m_ready[i]) dut_beats[i]++;
      end
      if (dut_count(1) > max_cnt1) max_cnt1 = dut_count(1);
   endtask

   task automatic update_model();
      for (int i = 0; i < N; i++) begin
         bit rdy, push, pop;
         rdy  = exp_ready(i);
         push = s_valid[i] && rdy;
         pop  = (exp_q[i].size() != 0) && m_ready[i];
         pending[i] = s_valid[i] && !rdy && !flush[i];
         if (flush[i]) begin
            exp_q[i].delete();
         end else begin
            if (pop) void'(exp_q[i].pop_front());
            if (push) exp_q[i].push_back(s_data[i]);
         end
      end
   endtask

   // Called at a falling edge with inputs already driven.
   task automatic cycle();
      #1;
      check_outputs();
      update_model();
      @(posedge clk);
      @(negedge clk);
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle_all();
      for (int i = 0; i < N; i++) begin
         flush[i]   = 1'b0;
         s_valid[i] = 1'b0;
         s_data[i]  = '0;
         m_ready[i] = 1'b0;
         pending[i] = 1'b0;
      end
   endtask

   task automatic rand_drive();
      for (int i = 0; i < N; i++) begin
         if (!pending[i]) begin
            s_valid[i] = ($urandom_range(0, 99) < 70);
            s_data[i]  = W'($urandom);
         end
         m_ready[i] = ($urandom_range(0, 99) < 60);
         flush[i]   = ($urandom_range(0, 99) < 4);
      end
   endtask

   task automatic check_reset_values(input string pfx);
      for (int i = 0; i < N; i++) begin
         check_eq($sformatf("%s.u%0d.m_valid", pfx, i), 32'(m_valid[i]), 32'(0));
         check_eq($sformatf("%s.u%0d.count", pfx, i), 32'(dut_count(i)), 32'(0));
         check_eq($sformatf("%s.u%0d.m_data", pfx, i), 32'(m_data[i]), 32'(NOP[i]));
         check_eq($sformatf("%s.u%0d.s_ready", pfx, i), 32'(s_ready[i]), 32'(1));
      end
   endtask

   // Reset asserted between clock edges; effect must be immediate.
   task automatic async_reset(input string pfx);
      idle_all();
      #3 rst_n = 1'b0;
      #1 check_reset_values(pfx);
      for (int i = 0; i < N; i++) exp_q[i].delete();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int beats0;
      for (int i = 0; i < N; i++) dut_beats[i] = 0;
      idle_all();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1 check_reset_values("por");
      @(negedge clk);
      rst_n = 1'b1;
      cycle();

      // Two pushes while downstream stalls, then drain.
      s_valid[0] = 1'b1; s_data[0] = 16'h000A; cycle();
      s_data[0] = 16'h000B; cycle();
      s_valid[0] = 1'b0;
      check_eq("fill.count", 32'(count_a), 32'(2));
      check_eq("fill.s_ready", 32'(s_ready[0]), 32'(0));
      check_eq("fill.head", 32'(m_data[0]), 32'h000A);
      m_ready[0] = 1'b1; cycle();
      check_eq("drain.second", 32'(m_data[0]), 32'h000B);
      check_eq("drain.second_valid", 32'(m_valid[0]), 32'(1));
      cycle();
      check_eq("drain.empty", 32'(m_valid[0]), 32'(0));
      m_ready[0] = 1'b0;

      // Reset while holding two entries.
      s_valid[0] = 1'b1; s_data[0] = 16'h0031; cycle();
      s_data[0] = 16'h0032; cycle();
      s_valid[0] = 1'b0;
      check_eq("pre_rst.count", 32'(count_a), 32'(2));
      async_reset("mid_rst");
      cycle();

      // Push and pop together at occupancy one.
      s_valid[0] = 1'b1; s_data[0] = 16'h0011; cycle();
      s_data[0] = 16'h000C; m_ready[0] = 1'b1; cycle();
      s_valid[0] = 1'b0; m_ready[0] = 1'b0;
      check_eq("pushpop.valid", 32'(m_valid[0]), 32'(1));
      check_eq("pushpop.head", 32'(m_data[0]), 32'h000C);
      check_eq("pushpop.count", 32'(count_a), 32'(1));
      m_ready[0] = 1'b1; cycle();
      m_ready[0] = 1'b0;

      // Flush with a concurrent push, from full and from half-full.
      s_valid[0] = 1'b1; s_data[0] = 16'h0021; cycle();
      s_data[0] = 16'h0022; cycle();
      flush[0] = 1'b1; s_data[0] = 16'h000D; cycle();
      flush[0] = 1'b0; s_valid[0] = 1'b0;
      check_eq("flush_full.count", 32'(count_a), 32'(0));
      check_eq("flush_full.valid", 32'(m_valid[0]), 32'(0));
      check_eq("flush_full.s_ready", 32'(s_ready[0]), 32'(1));
      s_valid[0] = 1'b1; s_data[0] = 16'h0023; cycle();
      flush[0] = 1'b1; s_data[0] = 16'h000D; cycle();
      flush[0] = 1'b0; s_valid[0] = 1'b0; m_ready[0] = 1'b1;
      check_eq("flush_half.count", 32'(count_a), 32'(0));
      check_eq("flush_half.data", 32'(m_data[0]), 32'(NOP[0]));
      repeat (2) cycle();
      idle_all();

      // Depth-1 pass-through: 100 back-to-back beats with downstream open.
      m_ready[2] = 1'b1;
      beats0 = dut_beats[2];
      for (int k = 0; k < 100; k++) begin
         s_valid[2] = 1'b1;
         s_data[2]  = W'(16'h1000 + k);
         cycle();
         check_eq("d1.no_bubble", 32'(m_valid[2]), 32'(1));
         check_eq("d1.latency", 32'(m_data[2]), 32'(16'h1000 + k));
         check_eq("d1.s_ready", 32'(s_ready[2]), 32'(1));
      end
      s_valid[2] = 1'b0;
      cycle();
      check_eq("d1.beats", 32'(dut_beats[2] - beats0), 32'(100));
      check_eq("d1.empty", 32'(m_valid[2]), 32'(0));
      idle_all();

      // Random traffic on all three, with occasional flushes.
      repeat (400) begin
         rand_drive();
         cycle();
      end
      idle_all();
      for (int i = 0; i < N; i++) m_ready[i] = 1'b1;
      repeat (4) cycle();
      check_eq("u1.max_count_le_3", 32'(max_cnt1 <= 3), 32'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
